// File: rtl/pick_fifo_pkg.sv
// Shared helpers for the tag-routed multi-channel FIFO: width formulas,
// tag extraction and fixed-priority arbitration.
package pick_fifo_pkg;

  // Widths never collapse to zero so single-entry corner cases still elaborate.
  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Tag lives in the top tag_width bits of a width-bit word.
  function automatic int get_tag(input logic [63:0] word, input int width,
                                 input int tag_width);
    logic [63:0] mask;
    mask = (64'd1 << tag_width) - 64'd1;
    return int'((word >> (width - tag_width)) & mask);
  endfunction

  // Highest set index among the low n bits; -1 when none is set.
  function automatic int highest_set(input logic [63:0] vec, input int n);
    int r;
    r = -1;
    for (int k = 0; k < 64; k++) begin
      if (k < n && vec[k]) r = k;
    end
    return r;
  endfunction

endpackage

// File: rtl/pick_fifo_chan.sv
// Single-channel queue: storage, write/read pointers, occupancy count and a
// registered read-data port. count is exported only with PICK_FIFO_LEVEL_EN.
module pick_fifo_chan
  import pick_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      ck,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty
`ifdef PICK_FIFO_LEVEL_EN
  , output logic [addr_w(DEPTH):0]  count
`endif
);

  localparam int AW = addr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_reg;
  logic [AW-1:0]    rp_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] rd_data_reg;

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge ck) begin
    if (wr_en) mem[wp_reg] <= wr_data;
  end

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wp_reg      <= '0;
      rp_reg      <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (wr_en) wp_reg <= wp_reg + AW'(1);
      if (rd_en) begin
        rp_reg      <= rp_reg + AW'(1);
        rd_data_reg <= mem[rp_reg];
      end
      count_reg <= count_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
`ifdef PICK_FIFO_LEVEL_EN
  assign count   = count_reg;
`endif

endmodule

// File: rtl/pick_fifo_mc.sv
// Tag-routed multi-channel FIFO top: write router, fixed-priority read arbiter,
// qualified output register and drop reporting. PICK_FIFO_LEVEL_EN adds level.
module pick_fifo_mc
  import pick_fifo_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 4,
  parameter  int FLUX       = 2,
  localparam int TAG_WIDTH  = tag_w(FLUX),
  localparam int ADDR_WIDTH = addr_w(DEPTH)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      datain,
  input  logic [FLUX-1:0]       rd,
  output logic [FLUX-1:0]       full,
  output logic [FLUX-1:0]       empty,
  output logic [WIDTH-1:0]      dataout,
  output logic                  dout_valid,
  output logic [TAG_WIDTH-1:0]  dout_tag,
  output logic                  drop
`ifdef PICK_FIFO_LEVEL_EN
  , output logic [FLUX*(ADDR_WIDTH+1)-1:0] level
`endif
);

  logic [TAG_WIDTH-1:0] wr_tag;
  logic [FLUX-1:0]      req;
  logic [FLUX-1:0]      grant_vec;
  logic [FLUX-1:0]      chan_wr;
  int                   grant_idx;
  logic                 grant_any;
  logic [TAG_WIDTH-1:0] grant_tag;
  logic                 wr_ok;
  logic [WIDTH-1:0]     chan_rdata [FLUX];

  logic                 dout_valid_reg;
  logic [TAG_WIDTH-1:0] dout_tag_reg;
  logic                 drop_reg;

  assign wr_tag = TAG_WIDTH'(get_tag(64'(datain), WIDTH, TAG_WIDTH));

  // Requests to empty channels are masked before arbitration so they never
  // shadow a lower channel that actually has data.
  assign req       = rd & ~empty;
  assign grant_idx = highest_set(64'(req), FLUX);
  assign grant_any = (grant_idx >= 0);
  assign grant_tag = grant_any ? TAG_WIDTH'(grant_idx) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_chan
      assign grant_vec[gi] = grant_any && (grant_idx == gi);
      // A full channel still takes the word when it is drained this same edge.
      assign chan_wr[gi]   = wr && (int'(wr_tag) == gi) &&
                             (!full[gi] || grant_vec[gi]);

      pick_fifo_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_chan (
        .ck      (ck),
        .rst     (rst),
        .wr_en   (chan_wr[gi]),
        .wr_data (datain),
        .rd_en   (grant_vec[gi]),
        .rd_data (chan_rdata[gi]),
        .full    (full[gi]),
        .empty   (empty[gi])
`ifdef PICK_FIFO_LEVEL_EN
        , .count (level[gi*(ADDR_WIDTH+1) +: ADDR_WIDTH+1])
`endif
      );
    end
  endgenerate

  // Unknown tags (tag >= FLUX) match no channel and therefore fall into drop.
  assign wr_ok = |chan_wr;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      dout_valid_reg <= 1'b0;
      dout_tag_reg   <= '0;
      drop_reg       <= 1'b0;
    end else begin
      dout_valid_reg <= grant_any;
      if (grant_any) dout_tag_reg <= grant_tag;
      drop_reg       <= wr && !wr_ok;
    end
  end

  // Each channel's read register only moves when that channel is granted,
  // which also retargets dout_tag, so this select holds between reads.
  assign dataout    = chan_rdata[dout_tag_reg];
  assign dout_valid = dout_valid_reg;
  assign dout_tag   = dout_tag_reg;
  assign drop       = drop_reg;

endmodule
